// File: rtl/div_sequencer.sv
// div_sequencer: sign handling and sequencing in front of a 32-bit unsigned
// iterative divider. It converts the operands to magnitudes, loads the divider
// and clocks it through its 32 iterations plus a finish cycle. It then applies
// sign correction and writes HI (remainder) and LO (quotient).
// A zero divisor is resolved here without starting the divider.
module div_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        div_rst_n,
    output logic        div_enabled,
    input  logic [31:0] div_hi,
    input  logic [31:0] div_lo
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    // Last RUN count: the divider needs 32 iterations plus 1 finish cycle.
    localparam logic [5:0] LAST_RUN_CNT = 6'd32;

    state_t      state_reg;
    state_t      state_next;
    logic [5:0]  cnt_reg;
    logic        neg_q_reg;
    logic        neg_r_reg;
    logic        done_reg;
    logic        div_by_zero_reg;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic [31:0] div_a_reg;
    logic [31:0] div_b_reg;
    logic        busy_dec;
    logic        div_rst_n_dec;
    logic        div_enabled_dec;

    // State register; reset abandons any in-flight divide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. A zero divisor never leaves IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start && (b != 32'd0)) state_next = LOAD;
            LOAD:    state_next = RUN;
            RUN:     if (cnt_reg == LAST_RUN_CNT) state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode from the state register only, so there is no
    // combinational path from the inputs.
    always_comb begin
        busy_dec        = 1'b0;
        div_rst_n_dec   = 1'b0;
        div_enabled_dec = 1'b0;
        case (state_reg)
            IDLE: begin
                busy_dec        = 1'b0;
                div_rst_n_dec   = 1'b0;
                div_enabled_dec = 1'b0;
            end
            LOAD: begin
                busy_dec        = 1'b1;
                div_rst_n_dec   = 1'b0;
                div_enabled_dec = 1'b0;
            end
            RUN: begin
                busy_dec        = 1'b1;
                div_rst_n_dec   = 1'b1;
                div_enabled_dec = 1'b1;
            end
            CAPTURE: begin
                busy_dec        = 1'b1;
                div_rst_n_dec   = 1'b1;
                div_enabled_dec = 1'b0;
            end
            default: begin
                busy_dec        = 1'b0;
                div_rst_n_dec   = 1'b0;
                div_enabled_dec = 1'b0;
            end
        endcase
    end

    // Datapath: operand magnitudes, sign flags, iteration count and results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg         <= 6'd0;
            neg_q_reg       <= 1'b0;
            neg_r_reg       <= 1'b0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            hi_reg          <= 32'd0;
            lo_reg          <= 32'd0;
            div_a_reg       <= 32'd0;
            div_b_reg       <= 32'd0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (b == 32'd0) begin
                            hi_reg          <= a;
                            lo_reg          <= 32'hFFFF_FFFF;
                            div_by_zero_reg <= 1'b1;
                            done_reg        <= 1'b1;
                        end else begin
                            // The magnitude of INT_MIN is itself, read as unsigned.
                            div_a_reg <= (is_signed && a[31]) ? -a : a;
                            div_b_reg <= (is_signed && b[31]) ? -b : b;
                            neg_q_reg <= is_signed & (a[31] ^ b[31]);
                            neg_r_reg <= is_signed & a[31];
                            cnt_reg   <= 6'd0;
                        end
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg + 6'd1;
                end
                CAPTURE: begin
                    lo_reg          <= neg_q_reg ? -div_lo : div_lo;
                    hi_reg          <= neg_r_reg ? -div_hi : div_hi;
                    div_by_zero_reg <= 1'b0;
                    done_reg        <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = busy_dec;
    assign div_rst_n   = div_rst_n_dec;
    assign div_enabled = div_enabled_dec;
    assign done        = done_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
    assign div_by_zero = div_by_zero_reg;
    assign div_a       = div_a_reg;
    assign div_b       = div_b_reg;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Control and sign-handling stage directly upstream of the 32-bit unsigned iterative divider in the multiply/divide unit. Accepts one signed or unsigned divide request, converts operands to magnitudes, loads and clocks the unsigned divider through its 32 iterations plus finish cycle, and applies sign correction. Writes the architectural HI (remainder) and LO (quotient) values. Divide-by-zero is resolved locally without running the divider.

## Interface
- No parameters; datapath fixed at 32 bits.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request pulse; sampled only in IDLE
- is_signed  in  1  1 = signed (two's complement) divide, 0 = unsigned; sampled with start
- a  in  32  dividend; sampled with start
- b  in  32  divisor; sampled with start
- busy  out  1  high in LOAD, RUN, CAPTURE
- done  out  1  one-cycle pulse: hi/lo/div_by_zero updated on the preceding edge
- hi  out  32  remainder result, held until next completion
- lo  out  32  quotient result, held until next completion
- div_by_zero  out  1  set with done when b == 0; held with hi/lo
- div_a  out  32  registered dividend magnitude to divider
- div_b  out  32  registered divisor magnitude to divider
- div_rst_n  out  1  divider's synchronous load/clear, active low
- div_enabled  out  1  divider iterate enable
- div_hi  in  32  divider remainder output
- div_lo  in  32  divider quotient output

## Operation
- States: IDLE, LOAD, RUN, CAPTURE. 6-bit iteration counter cnt.
- IDLE: div_rst_n = 0, div_enabled = 0.
  - start && b != 0 → LOAD. Register div_a = (is_signed && a[31]) ? -a : a and div_b likewise from b. Register neg_q = is_signed & (a[31] ^ b[31]) and neg_r = is_signed & a[31]. Clear cnt.
  - start && b == 0 → stay IDLE. On the same edge: hi = a, lo = 32'hFFFF_FFFF, div_by_zero = 1, done = 1 next cycle.
- LOAD (1 cycle): div_rst_n = 0, div_enabled = 0. The divider loads div_a at the end of this cycle. → RUN.
- RUN: div_rst_n = 1, div_enabled = 1, cnt increments each edge. This covers the divider's 32 iterations plus its finish cycle. Leave RUN on the edge where cnt == 32 (33 RUN cycles) → CAPTURE.
- CAPTURE (1 cycle): div_enabled = 0, div_rst_n = 1.
  - On exit edge: lo = neg_q ? -div_lo : div_lo; hi = neg_r ? -div_hi : div_hi; div_by_zero = 0; done = 1 next cycle. → IDLE.
- Arithmetic: negation is 32-bit two's complement with wrap.
  - INT_MIN magnitude is 0x8000_0000 as unsigned.
  - Signed 0x8000_0000 / -1 therefore yields lo = 0x8000_0000, hi = 0. No trap.
- start while busy is ignored and not queued.
- done and start in the same cycle: the start is accepted, because the state is IDLE during the done cycle.
- Async reset, including mid-operation: state = IDLE, cnt = 0, busy = 0, done = 0, hi = 0, lo = 0, div_by_zero = 0, div_a = 0, div_b = 0, div_rst_n = 0, div_enabled = 0. The in-flight operation is discarded and produces no done.

## Timing
- Edge E0 samples start, from IDLE.
- Normal divide:
  - LOAD cycle follows E0. The divider loads at E1.
  - RUN edges are E2..E34; the divider result is stable after E34.
  - CAPTURE edge E35 writes hi/lo.
  - done is high in the cycle after E35.
  - Latency: 35 edges from the start-sampling edge to the result edge. Issue rate: one operation per 36 cycles.
- Divide-by-zero: result is written at E0; done is high in the cycle after E0 (latency 1).
- busy rises after E0 and falls after E35. It is never high for divide-by-zero.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset, then unsigned a = 100, b = 7 → done exactly 36 cycles after the start cycle; lo = 14, hi = 2, div_by_zero = 0; busy high for 35 cycles.
- Signed a = 0xFFFF_FFF9 (-7), b = 2 → lo = 0xFFFF_FFFD (-3), hi = 0xFFFF_FFFF (-1). Signed a = 7, b = 0xFFFF_FFFE (-2) → lo = 0xFFFF_FFFD, hi = 1.
- Signed a = 0x8000_0000, b = 0xFFFF_FFFF → lo = 0x8000_0000, hi = 0. Unsigned a = 0xFFFF_FFFF, b = 1 → lo = 0xFFFF_FFFF, hi = 0.
- a = 0x1234, b = 0, either signedness → done next cycle, hi = 0x1234, lo = 0xFFFF_FFFF, div_by_zero = 1, busy never high.
- During RUN, pulse start with a = 9, b = 3 → ignored; the original result is unchanged. Assert start in the done cycle → accepted, second result correct.
- Drop rst_n at RUN cnt = 10 → all outputs return to reset values immediately. No done. A following unsigned 50 / 5 → lo = 10, hi = 0.
